frame_sync_buffer: RTL
======================

Name: frame_sync_buffer

Overview:
- Parametrised, multi-channel, frame-synchronous double buffer in the VGA pixel-clock domain.
- Captures a coherent snapshot of game-side state (obstacle coordinates, player position, mode) when the producer signals an update via a toggle handshake.
- Commits that snapshot to the display-side outputs only at the start of the vertical sync pulse, so a frame never mixes old and new data.
- Adds overrun counting, freeze, and configurable sync polarity and synchronizer depth.

Parameters:
- NUM_CH, 10: number of data channels.
- DATA_W, 10: bits per channel.
- RST_VAL, 700: reset value loaded into every channel of the shadow and front buffers; truncated to DATA_W.
- VS_ACTIVE_LOW, 1: 1 means the sync pulse is vs==0; 0 means vs==1.
- SYNC_STAGES, 2: synchronizer flops on upd_toggle; minimum 2.
- CNT_W, 8: overrun counter width.

Ports:
- clk  in  1  pixel clock (25 MHz).
- rst  in  1  synchronous, active-high reset.
- upd_toggle  in  1  producer level toggles once per new data set; asynchronous to clk. din is stable from before each toggle until the next toggle.
- din  in  NUM_CH*DATA_W  producer data, channel i at bits [i*DATA_W +: DATA_W].
- vs  in  1  vertical sync from the VGA controller.
- freeze  in  1  1 suppresses commits; the display holds its current frame.
- dout  out  NUM_CH*DATA_W  committed front buffer, same packing as din.
- pending  out  1  shadow holds data not yet committed.
- swap_pulse  out  1  one-cycle pulse, coincident with a dout update.
- overrun_cnt  out  CNT_W  count of shadow overwrites before commit; saturating.

Behaviour:
- Reset (rst sampled 1 on a clk edge):
  - Shadow and dout: all channels = RST_VAL.
  - pending=0, swap_pulse=0, overrun_cnt=0.
  - Sync chain and its delayed copy = 0; VS history = inactive level.
  - Reset mid-operation discards any pending data. The producer resets its toggle to 0.
- Toggle detect:
  - Sync chain s[0..SYNC_STAGES-1], plus s_d, a one-cycle delay of the last stage.
  - upd_ev = s[last] XOR s_d.
  - Latency: a toggle change settled before edge k captures din into shadow on edge k+SYNC_STAGES.
- VS detect:
  - vs_act = vs XOR VS_ACTIVE_LOW ... defined so that vs_act=1 during the sync pulse.
  - vs_d is the registered vs_act.
  - blank_ev = vs_act AND NOT vs_d; one cycle per frame.
- State machine, two states:
  - IDLE (pending=0):
    - upd_ev: shadow <= din, go to PENDING.
    - blank_ev alone: no action.
  - PENDING (pending=1):
    - blank_ev and NOT freeze: dout <= shadow, swap_pulse=1 next cycle, go to IDLE.
    - blank_ev and freeze: no commit, stay in PENDING.
    - upd_ev without a commit: shadow <= din, overrun_cnt += 1 (saturates at 2^CNT_W-1), stay in PENDING.
    - upd_ev and commit on the same edge: dout <= old shadow, shadow <= din, stay in PENDING, no overrun, swap_pulse=1.
- swap_pulse and dout are registered together, so swap_pulse is high in the cycle dout first shows the new value.
- Deasserting freeze takes effect only at the next blank_ev; there is no retroactive commit.
- dout changes only on a commit edge, never mid-frame.
- Channels are copied wholesale; there is no per-channel masking.

Decomposition:
- Package frame_sync_pkg:
  - state enum fsb_state_t {FSB_IDLE, FSB_PENDING}.
  - Default-parameter localparams.
  - Saturating-increment function.
- Sub-module toggle_sync: parameter SYNC_STAGES; ports clk, rst, tog_in, ev_out. Implements the sync chain, s_d and XOR.
- VS edge logic, state machine and buffers stay in frame_sync_buffer.

Test Plan (NUM_CH=4, DATA_W=10, RST_VAL=700, SYNC_STAGES=2, VS_ACTIVE_LOW=1):
1. Reset, then hold vs=1 and upd_toggle=0 for 100 cycles -> every dout channel = 700; pending=0; overrun_cnt=0; swap_pulse never asserts.
2. din={40,30,20,10}, toggle 0->1 before edge k -> pending=1 after edge k+2; dout still 700. Drive vs=0 -> after the next edge dout={40,30,20,10}, swap_pulse high exactly one cycle, pending=0.
3. Three toggles with din=1, 2, 3 and no vs pulse -> overrun_cnt=2, pending=1. Next vs pulse -> dout all channels = 3. With CNT_W=2 and 6 overruns -> overrun_cnt saturates at 3.
4. Schedule upd_ev on the same edge as blank_ev while the shadow holds 5 and din=6 -> dout=5, shadow=6, pending=1, overrun_cnt unchanged; the following vs pulse -> dout=6.
5. freeze=1 with pending data 9, two vs pulses -> dout unchanged, pending=1, no swap_pulse. Clear freeze, next vs pulse -> dout=9.
6. Assert rst while in PENDING with shadow=9 -> next edge dout=700, pending=0, overrun_cnt=0. A later vs pulse produces no swap.

Source files
------------

// File: rtl/frame_sync_buffer_pkg.sv
// Shared types, defaults and helpers for the frame-synchronous
// double buffer.
package frame_sync_pkg;

    typedef enum logic [0:0] {
        FSB_IDLE    = 1'b0,
        FSB_PENDING = 1'b1
    } fsb_state_t;

    localparam int FSB_NUM_CH      = 10;
    localparam int FSB_DATA_W      = 10;
    localparam int FSB_RST_VAL     = 700;
    localparam bit FSB_VS_ACT_LOW  = 1'b1;
    localparam int FSB_SYNC_STAGES = 2;
    localparam int FSB_CNT_W       = 8;

    // Increment that sticks at the all-ones value of a w-bit field.
    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input int          w
    );
        logic [31:0] max_v;
        max_v = 32'hFFFF_FFFF >> (32 - w);
        return (v == max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/frame_sync_buffer_if.sv
// Producer/display bundle for frame_sync_buffer.
// The master side drives data in and consumes the committed frame.
interface frame_sync_buffer_if #(
    parameter int NUM_CH = 10,
    parameter int DATA_W = 10,
    parameter int CNT_W  = 8
);
    logic                     upd_toggle;
    logic [NUM_CH*DATA_W-1:0] din;
    logic                     vs;
    logic                     freeze;
    logic [NUM_CH*DATA_W-1:0] dout;
    logic                     pending;
    logic                     swap_pulse;
    logic [CNT_W-1:0]         overrun_cnt;

    modport master (
        output upd_toggle, din, vs, freeze,
        input  dout, pending, swap_pulse, overrun_cnt
    );

    modport slave (
        input  upd_toggle, din, vs, freeze,
        output dout, pending, swap_pulse, overrun_cnt
    );
endinterface

// File: rtl/frame_sync_buffer_toggle_sync.sv
// Synchronises an asynchronous toggle into clk and emits a one-cycle
// event for every change of its level.
module toggle_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tog_in,
    output logic ev_out
);
    logic [SYNC_STAGES-1:0] s;
    logic                   s_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            s   <= '0;
            s_d <= 1'b0;
        end else begin
            s   <= {s[SYNC_STAGES-2:0], tog_in};
            s_d <= s[SYNC_STAGES-1];
        end
    end

    assign ev_out = s[SYNC_STAGES-1] ^ s_d;
endmodule

// File: rtl/frame_sync_buffer.sv
// Frame-synchronous double buffer: captures producer snapshots into a
// shadow and commits them to the display only at vsync start.
module frame_sync_buffer
    import frame_sync_pkg::*;
#(
    parameter int NUM_CH        = FSB_NUM_CH,
    parameter int DATA_W        = FSB_DATA_W,
    parameter int RST_VAL       = FSB_RST_VAL,
    parameter bit VS_ACTIVE_LOW = FSB_VS_ACT_LOW,
    parameter int SYNC_STAGES   = FSB_SYNC_STAGES,
    parameter int CNT_W         = FSB_CNT_W
) (
    input logic               clk,
    input logic               rst,
    frame_sync_buffer_if.slave bus
);
    localparam int W = NUM_CH * DATA_W;
    localparam logic [DATA_W-1:0] RV = DATA_W'(RST_VAL);

    fsb_state_t       state_q;
    fsb_state_t       state_d;
    logic [W-1:0]     shadow_q;
    logic [W-1:0]     front_q;
    logic             swap_q;
    logic [CNT_W-1:0] ovr_q;
    logic             vs_d;
    logic             vs_act;
    logic             upd_ev;
    logic             blank_ev;
    logic             pending;
    logic             commit;

    toggle_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_tsync (
        .clk   (clk),
        .rst   (rst),
        .tog_in(bus.upd_toggle),
        .ev_out(upd_ev)
    );

    assign vs_act   = bus.vs ^ VS_ACTIVE_LOW;
    assign blank_ev = vs_act & ~vs_d;
    assign pending  = (state_q == FSB_PENDING);
    assign commit   = pending & blank_ev & ~bus.freeze;

    // A capture on the commit edge refills the shadow, so stay pending.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FSB_IDLE:
                if (upd_ev) state_d = FSB_PENDING;
            FSB_PENDING:
                if (commit && !upd_ev) state_d = FSB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FSB_IDLE;
            shadow_q <= {NUM_CH{RV}};
            front_q  <= {NUM_CH{RV}};
            swap_q   <= 1'b0;
            ovr_q    <= '0;
            vs_d     <= 1'b0;
        end else begin
            state_q <= state_d;
            vs_d    <= vs_act;
            swap_q  <= commit;
            if (commit)
                front_q <= shadow_q;
            if (upd_ev)
                shadow_q <= bus.din;
            if (upd_ev && pending && !commit)
                ovr_q <= CNT_W'(sat_inc(32'(ovr_q), CNT_W));
        end
    end

    assign bus.dout        = front_q;
    assign bus.pending     = pending;
    assign bus.swap_pulse  = swap_q;
    assign bus.overrun_cnt = ovr_q;
endmodule
